dyadic_boolean_accumulator: RTL and testbench

//  Registered, flow-controlled successor to the combinational dyadic Boolean operator.

---
 rtl/dyadic_boolean_pkg.sv | 29 ++
 rtl/dyadic_boolean_lut.sv | 20 ++
 rtl/dyadic_boolean_accumulator.sv | 110 +++++++++++
 tb/tb_dyadic_boolean_accumulator.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/dyadic_boolean_pkg.sv
// Shared constants for the dyadic Boolean accumulator: op truth tables, modes, field widths.
// Optional flag outputs are enabled by defining DYADIC_BOOLEAN_ACCUMULATOR_FLAGS_EN.
package dyadic_boolean_pkg;

   localparam int unsigned OP_WIDTH   = 4;
   localparam int unsigned MODE_WIDTH = 2;

   // Truth tables indexed by {x,y}: bit0 x=0,y=0 .. bit3 x=1,y=1
   localparam logic [OP_WIDTH-1:0] BOOL_ZERO  = 4'b0000;
   localparam logic [OP_WIDTH-1:0] BOOL_NOR   = 4'b0001;
   localparam logic [OP_WIDTH-1:0] BOOL_NOT_A = 4'b0011;
   localparam logic [OP_WIDTH-1:0] BOOL_NOT_B = 4'b0101;
   localparam logic [OP_WIDTH-1:0] BOOL_XOR   = 4'b0110;
   localparam logic [OP_WIDTH-1:0] BOOL_NAND  = 4'b0111;
   localparam logic [OP_WIDTH-1:0] BOOL_AND   = 4'b1000;
   localparam logic [OP_WIDTH-1:0] BOOL_XNOR  = 4'b1001;
   localparam logic [OP_WIDTH-1:0] BOOL_B     = 4'b1010;
   localparam logic [OP_WIDTH-1:0] BOOL_A     = 4'b1100;
   localparam logic [OP_WIDTH-1:0] BOOL_OR    = 4'b1110;
   localparam logic [OP_WIDTH-1:0] BOOL_ONES  = 4'b1111;

   typedef enum logic [MODE_WIDTH-1:0] {
      MODE_DIRECT = 2'd0,
      MODE_ACCUM  = 2'd1,
      MODE_LOAD   = 2'd2,
      MODE_CLEAR  = 2'd3
   } mode_e;

endpackage

// File: rtl/dyadic_boolean_lut.sv
// Combinational per-bit Boolean function: o[i] = op[{x[i],y[i]}].
module dyadic_boolean_lut
   import dyadic_boolean_pkg::*;
#(
   parameter int unsigned WORD_WIDTH = 36
) (
   input  logic [OP_WIDTH-1:0]   op,
   input  logic [WORD_WIDTH-1:0] x,
   input  logic [WORD_WIDTH-1:0] y,
   output logic [WORD_WIDTH-1:0] o
);

   always_comb begin
      o = '0;
      for (int i = 0; i < int'(WORD_WIDTH); i++) begin
         o[i] = op[{x[i], y[i]}];
      end
   end

endmodule

// File: rtl/dyadic_boolean_accumulator.sv
// Registered valid/ready Boolean ALU stage with a chaining accumulator and saturating op counter.
// Define DYADIC_BOOLEAN_ACCUMULATOR_FLAGS_EN to build the registered out_zero/out_ones flags.
module dyadic_boolean_accumulator
   import dyadic_boolean_pkg::*;
#(
   parameter int unsigned WORD_WIDTH  = 36,
   parameter int unsigned COUNT_WIDTH = 8
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [OP_WIDTH-1:0]    op,
   input  logic [MODE_WIDTH-1:0]  mode,
   input  logic [WORD_WIDTH-1:0]  a,
   input  logic [WORD_WIDTH-1:0]  b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WORD_WIDTH-1:0]  o,
   output logic [COUNT_WIDTH-1:0] acc_count,
   output logic                   out_zero,
   output logic                   out_ones
);

   logic [WORD_WIDTH-1:0]  acc;
   logic [WORD_WIDTH-1:0]  lut_x;
   logic [WORD_WIDTH-1:0]  lut_o;
   logic [WORD_WIDTH-1:0]  result;
   logic [WORD_WIDTH-1:0]  acc_next;
   logic [COUNT_WIDTH-1:0] count_next;
   logic                   accept;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   // Single LUT shared by DIRECT and ACCUM; x selects the accumulator when chaining
   assign lut_x = (mode_e'(mode) == MODE_ACCUM) ? acc : a;

   dyadic_boolean_lut #(
      .WORD_WIDTH(WORD_WIDTH)
   ) u_lut (
      .op(op),
      .x (lut_x),
      .y (b),
      .o (lut_o)
   );

   always_comb begin
      result     = lut_o;
      acc_next   = acc;
      count_next = acc_count;
      case (mode_e'(mode))
         MODE_DIRECT: begin
            result = lut_o;
         end
         MODE_ACCUM: begin
            result     = lut_o;
            acc_next   = lut_o;
            count_next = (acc_count == {COUNT_WIDTH{1'b1}}) ? acc_count
                                                             : acc_count + COUNT_WIDTH'(1);
         end
         MODE_LOAD: begin
            result     = a;
            acc_next   = a;
            count_next = '0;
         end
         MODE_CLEAR: begin
            result     = '0;
            acc_next   = '0;
            count_next = '0;
         end
         default: begin
            result = lut_o;
         end
      endcase
   end

   // State only moves on accept, so stalled outputs and acc stay put
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         o         <= '0;
         acc       <= '0;
         acc_count <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         o         <= result;
         acc       <= acc_next;
         acc_count <= count_next;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef DYADIC_BOOLEAN_ACCUMULATOR_FLAGS_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_zero <= 1'b0;
         out_ones <= 1'b0;
      end else if (accept) begin
         out_zero <= (result == '0);
         out_ones <= (result == {WORD_WIDTH{1'b1}});
      end
   end
`else
   assign out_zero = 1'b0;
   assign out_ones = 1'b0;
`endif

endmodule

// File: tb/tb_dyadic_boolean_accumulator.sv
// Directed bench for dyadic_boolean_accumulator at WORD_WIDTH=8, COUNT_WIDTH=2.
module tb_dyadic_boolean_accumulator;
   import dyadic_boolean_pkg::*;

   localparam int unsigned WW = 8;
   localparam int unsigned CW = 2;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    op;
   logic [1:0]    mode;
   logic [WW-1:0] a;
   logic [WW-1:0] b;
   logic          out_valid;
   logic          out_ready;
   logic [WW-1:0] o;
   logic [CW-1:0] acc_count;
   logic          out_zero;
   logic          out_ones;

   int errors = 0;
   int checks = 0;

   dyadic_boolean_accumulator #(
      .WORD_WIDTH (WW),
      .COUNT_WIDTH(CW)
   ) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .op       (op),
      .mode     (mode),
      .a        (a),
      .b        (b),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .o        (o),
      .acc_count(acc_count),
      .out_zero (out_zero),
      .out_ones (out_ones)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Present one transaction, let it be accepted on the next edge, sample 1ns later
   task automatic send(input logic [1:0] m, input logic [3:0] f,
                       input logic [WW-1:0] va, input logic [WW-1:0] vb);
      mode     = m;
      op       = f;
      a        = va;
      b        = vb;
      in_valid = 1'b1;
      @(posedge clock);
      #1;
   endtask

   // a=F0, b=CC: expected o for op = 0..15
   logic [WW-1:0] direct_exp [16] = '{8'h00, 8'h03, 8'h0C, 8'h0F, 8'h30, 8'h33, 8'h3C, 8'h3F,
                                      8'hC0, 8'hC3, 8'hCC, 8'hCF, 8'hF0, 8'hF3, 8'hFC, 8'hFF};
   logic [CW-1:0] sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
   logic          flag_en;

   initial begin
`ifdef DYADIC_BOOLEAN_ACCUMULATOR_FLAGS_EN
      flag_en = 1'b1;
`else
      flag_en = 1'b0;
`endif
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      op        = '0;
      mode      = '0;
      a         = '0;
      b         = '0;
      repeat (2) @(posedge clock);
      #2;
      reset_n = 1'b1;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_o", 32'(o), 32'd0);
      check("rst_count", 32'(acc_count), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_flags", 32'({out_zero, out_ones}), 32'd0);
      @(posedge clock);
      #1;

      // Test 1: all 16 ops in DIRECT mode
      for (int k = 0; k < 16; k++) begin
         send(MODE_DIRECT, 4'(k), 8'hF0, 8'hCC);
         check($sformatf("direct_op%0d", k), 32'(o), 32'(direct_exp[k]));
         check("direct_valid", 32'(out_valid), 32'd1);
      end
      check("direct_count", 32'(acc_count), 32'd0);
      in_valid = 1'b0;
      @(posedge clock);
      #1;
      check("drain_valid", 32'(out_valid), 32'd0);

      // Test 2: LOAD then back-to-back ACCUM chain
      send(MODE_LOAD, BOOL_XOR, 8'hFF, 8'h00);
      check("load_o", 32'(o), 32'hFF);
      check("load_count", 32'(acc_count), 32'd0);
      send(MODE_ACCUM, BOOL_AND, 8'h00, 8'h0F);
      check("acc_and_o", 32'(o), 32'h0F);
      check("acc_and_count", 32'(acc_count), 32'd1);
      send(MODE_ACCUM, BOOL_XOR, 8'h00, 8'h3C);
      check("acc_xor_o", 32'(o), 32'h33);
      check("acc_xor_count", 32'(acc_count), 32'd2);
      send(MODE_ACCUM, BOOL_OR, 8'h00, 8'h01);
      check("acc_or_o", 32'(o), 32'h33);
      check("acc_or_count", 32'(acc_count), 32'd3);

      // Test 3: stall with a pending ACCUM XOR FF
      out_ready = 1'b0;
      mode      = MODE_ACCUM;
      op        = BOOL_XOR;
      b         = 8'hFF;
      in_valid  = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         check("stall_in_ready", 32'(in_ready), 32'd0);
         check("stall_o", 32'(o), 32'h33);
         check("stall_valid", 32'(out_valid), 32'd1);
         @(posedge clock);
         #1;
      end
      out_ready = 1'b1;
      #1;
      check("release_in_ready", 32'(in_ready), 32'd1);
      @(posedge clock);
      #1;
      check("release_o", 32'(o), 32'hCC);
      check("release_count", 32'(acc_count), 32'd3);
      in_valid = 1'b0;

      // Test 4: counter saturation, then CLEAR
      send(MODE_LOAD, BOOL_ZERO, 8'h55, 8'h00);
      check("sat_load_count", 32'(acc_count), 32'd0);
      for (int k = 0; k < 5; k++) begin
         send(MODE_ACCUM, BOOL_AND, 8'h00, 8'hFF);
         check($sformatf("sat_count%0d", k), 32'(acc_count), 32'(sat_exp[k]));
         check($sformatf("sat_o%0d", k), 32'(o), 32'h55);
      end
      send(MODE_CLEAR, BOOL_ONES, 8'hFF, 8'hFF);
      check("clear_o", 32'(o), 32'h00);
      check("clear_count", 32'(acc_count), 32'd0);

      // Test 5: async reset between edges drops state
      send(MODE_LOAD, BOOL_ZERO, 8'hAA, 8'h00);
      send(MODE_ACCUM, BOOL_OR, 8'h00, 8'h01);
      check("pre_rst_o", 32'(o), 32'hAB);
      check("pre_rst_count", 32'(acc_count), 32'd1);
      mode = MODE_ACCUM;
      b    = 8'h0F;
      #2;
      reset_n = 1'b0;
      #1;
      check("midrst_valid", 32'(out_valid), 32'd0);
      check("midrst_o", 32'(o), 32'd0);
      check("midrst_count", 32'(acc_count), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      @(posedge clock);
      #2;
      reset_n = 1'b1;
      #1;
      send(MODE_ACCUM, BOOL_OR, 8'h00, 8'h0F);
      check("postrst_o", 32'(o), 32'h0F);
      check("postrst_count", 32'(acc_count), 32'd1);

      // Test 6: flags
      send(MODE_DIRECT, BOOL_ZERO, 8'h12, 8'h34);
      check("zero_o", 32'(o), 32'h00);
      check("zero_flag", 32'(out_zero), 32'(flag_en));
      check("zero_ones_flag", 32'(out_ones), 32'd0);
      send(MODE_DIRECT, BOOL_ONES, 8'h12, 8'h34);
      check("ones_o", 32'(o), 32'hFF);
      check("ones_flag", 32'(out_ones), 32'(flag_en));
      check("ones_zero_flag", 32'(out_zero), 32'd0);
      send(MODE_DIRECT, BOOL_XOR, 8'h12, 8'h34);
      check("mid_flags", 32'({out_zero, out_ones}), 32'd0);
      in_valid = 1'b0;
      @(posedge clock);
      #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
